// File: rtl/sram_march_pkg.sv
// Shared types and constants for the March C- SRAM self-test sequencer:
// FSM states, per-element op descriptors and the data backgrounds.
package sram_march_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One March element: walk direction, one or two ops, and for each op
    // whether it reads (else writes) and whether it uses ~B instead of B.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_rd;
        logic op0_inv;
        logic op1_rd;
        logic op1_inv;
    } elem_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;
    localparam logic [7:0] BG_PASS0  = 8'h00;
    localparam logic [7:0] BG_PASS1  = 8'h55;

    function automatic elem_t elem_desc(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{down: 1'b0, two_ops: 1'b0, op0_rd: 1'b0, op0_inv: 1'b0, op1_rd: 1'b0, op1_inv: 1'b0};
            3'd1:    return '{down: 1'b0, two_ops: 1'b1, op0_rd: 1'b1, op0_inv: 1'b0, op1_rd: 1'b0, op1_inv: 1'b1};
            3'd2:    return '{down: 1'b0, two_ops: 1'b1, op0_rd: 1'b1, op0_inv: 1'b1, op1_rd: 1'b0, op1_inv: 1'b0};
            3'd3:    return '{down: 1'b1, two_ops: 1'b1, op0_rd: 1'b1, op0_inv: 1'b0, op1_rd: 1'b0, op1_inv: 1'b1};
            3'd4:    return '{down: 1'b1, two_ops: 1'b1, op0_rd: 1'b1, op0_inv: 1'b1, op1_rd: 1'b0, op1_inv: 1'b0};
            3'd5:    return '{down: 1'b0, two_ops: 1'b0, op0_rd: 1'b1, op0_inv: 1'b0, op1_rd: 1'b0, op1_inv: 1'b0};
            default: return '0;
        endcase
    endfunction

    function automatic logic elem_down(input logic [2:0] idx);
        elem_t d;
        d = elem_desc(idx);
        return d.down;
    endfunction

endpackage

// File: rtl/sram_march_chk.sv
// Read-data checker: one pending-read slot, comparator against s_qdata,
// sticky first-failure capture and a saturating miscompare counter.
module sram_march_chk #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] s_qdata,
    input  logic              clr,
    input  logic              flush,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [15:0]       err_cnt
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_exp;
    logic              miscmp;

    // s_qdata belongs to the read registered one cycle earlier
    assign miscmp = pend_valid && !flush && (s_qdata != pend_exp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_exp   <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            err_cnt    <= '0;
        end else begin
            pend_valid <= rd_valid && !flush && !clr;
            pend_addr  <= rd_addr;
            pend_exp   <= rd_exp;
            if (clr) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_exp  <= '0;
                fail_got  <= '0;
                err_cnt   <= '0;
            end else if (miscmp) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= pend_addr;
                    fail_exp  <= pend_exp;
                    fail_got  <= s_qdata;
                end
            end
        end
    end

endmodule

// File: rtl/sram_march_ctrl.sv
// March C- self-test sequencer driving the SRAM strobes directly.
// Define SRAM_MARCH_BG_EN to add a second pass with background 8'h55.
module sram_march_ctrl
    import sram_march_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [15:0]       err_cnt,
    output logic              s_cen,
    output logic              s_oen,
    output logic              s_wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_ddata,
    input  logic [DATA_W-1:0] s_qdata,
    output state_t            state_dbg
);

`ifdef SRAM_MARCH_BG_EN
    localparam bit TWO_PASS = 1'b1;
`else
    localparam bit TWO_PASS = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [2:0]        elem, elem_n;
    logic              op, op_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              pass, pass_n;
    logic              start_ok;
    elem_t             desc;
    logic              last_op, last_addr, running;
    logic              cur_rd, cur_inv;
    logic [DATA_W-1:0] bg, cur_data;

    assign desc      = elem_desc(elem);
    assign last_op   = !desc.two_ops || op;
    assign last_addr = desc.down ? (addr == '0) : (addr == TOP_ADDR);
    assign running   = (state == RUN);
    assign cur_rd    = op ? desc.op1_rd  : desc.op0_rd;
    assign cur_inv   = op ? desc.op1_inv : desc.op0_inv;
    assign bg        = pass ? DATA_W'(BG_PASS1) : DATA_W'(BG_PASS0);
    assign cur_data  = cur_inv ? ~bg : bg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            elem  <= '0;
            op    <= 1'b0;
            addr  <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            elem  <= elem_n;
            op    <= op_n;
            addr  <= addr_n;
            pass  <= pass_n;
        end
    end

    // start is a one-cycle request taken only in IDLE/DONE; abort is a level
    // that wins over start and every RUN/DRAIN transition.
    always_comb begin
        state_n  = state;
        elem_n   = elem;
        op_n     = op;
        addr_n   = addr;
        pass_n   = pass;
        start_ok = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n  = RUN;
                        elem_n   = '0;
                        op_n     = 1'b0;
                        addr_n   = '0;
                        pass_n   = 1'b0;
                        start_ok = 1'b1;
                    end
                end
                RUN: begin
                    if (!last_op) begin
                        op_n = 1'b1;
                    end else begin
                        op_n = 1'b0;
                        if (!last_addr) begin
                            addr_n = desc.down ? addr - 1'b1 : addr + 1'b1;
                        end else if (elem != LAST_ELEM) begin
                            elem_n = elem + 3'd1;
                            addr_n = elem_down(elem + 3'd1) ? TOP_ADDR : '0;
                        end else if (TWO_PASS && !pass) begin
                            pass_n = 1'b1;
                            elem_n = '0;
                            addr_n = '0;
                        end else begin
                            state_n = DRAIN;
                        end
                    end
                end
                DRAIN:   state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Strobes decode from registered state so reset clears them without a clock
    assign s_cen     = !running;
    assign s_wen     = !(running && !cur_rd);
    assign s_oen     = !(running && cur_rd);
    assign s_addr    = running ? addr : '0;
    assign s_ddata   = (running && !cur_rd) ? cur_data : '0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    sram_march_chk #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_chk (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_valid (running && cur_rd),
        .rd_addr  (addr),
        .rd_exp   (cur_data),
        .s_qdata  (s_qdata),
        .clr      (start_ok),
        .flush    (abort),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got),
        .err_cnt  (err_cnt)
    );

endmodule
